// File: rtl/mem_mdl_pkg.sv
// Shared types and helpers for the pipelined memory model.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_mdl_pkg;

   // Controller state: clearing the array after reset, or serving traffic.
   typedef enum logic {ST_INIT, ST_RUN} mem_st_e;

   // Deepest read pipe supported.
   localparam int MEM_MAX_RD_LAT = 4;

   // Number of byte lanes in a data word.
   function automatic int mem_lanes(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipe: shifts {valid, data} through P_LAT stages to the read port.
// Latency: P_LAT cycles from ld_vld at a rising edge to rd_vld.
// Backpressure: none; one load per cycle, the pipe always advances.
// Ports: clk, rst_n (async, active-low); ld_vld/ld_dat load stage 0 from the
//        array read; rd_vld/rd_dat are the registered output stage.
module mem_rd_pipe #(
   parameter int P_DW  = 32,
   parameter int P_LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_vld,
   input  logic [P_DW-1:0] ld_dat,
   output logic            rd_vld,
   output logic [P_DW-1:0] rd_dat
);

   logic [P_LAT-1:0] vld;
   logic [P_DW-1:0]  dat [P_LAT];

   // Data is zeroed on entry when the slot is empty, so every stage -- and in
   // particular the output register -- holds zero whenever its valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < P_LAT; i++) dat[i] <= '0;
      end else begin
         vld[0] <= ld_vld;
         dat[0] <= ld_vld ? ld_dat : '0;
         for (int i = 1; i < P_LAT; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign rd_vld = vld[P_LAT-1];
   assign rd_dat = dat[P_LAT-1];

endmodule

// File: rtl/mem_mdl_pipe.sv
// Single-port synchronous memory model with byte enables and optional post-reset clear.
// Latency: writes land at the accepting edge; reads return P_RD_LAT cycles later.
// Backpressure: m_ready low only while clearing after reset; otherwise one request per cycle.
// Ports: clk, rst_n (async, active-low); m_cs/m_rw/m_addr/m_wdata/m_be request;
//        m_ready accept flag; m_rdata/m_rvalid registered read return.
module mem_mdl_pipe
   import mem_mdl_pkg::*;
#(
   parameter int P_MEM_DW  = 32,
   parameter int P_MEM_AW  = 10,
   parameter int P_RD_LAT  = 2,
   parameter int P_INIT_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m_cs,
   input  logic                  m_rw,
   input  logic [P_MEM_AW-1:0]   m_addr,
   input  logic [P_MEM_DW-1:0]   m_wdata,
   input  logic [P_MEM_DW/8-1:0] m_be,
   output logic                  m_ready,
   output logic [P_MEM_DW-1:0]   m_rdata,
   output logic                  m_rvalid
);

   localparam int LANES = mem_lanes(P_MEM_DW);
   localparam int DEPTH = 2 ** P_MEM_AW;

   if ((P_MEM_DW % 8) != 0 || P_RD_LAT < 1 || P_RD_LAT > MEM_MAX_RD_LAT) begin : g_bad_param
      $error("mem_mdl_pipe: P_MEM_DW must be a multiple of 8 and P_RD_LAT within 1..4");
   end

   mem_st_e             st;
   mem_st_e             st_nxt;
   logic [P_MEM_AW-1:0] cnt;
   logic [P_MEM_DW-1:0] mem [DEPTH];
   logic                wr_acc;
   logic                rd_acc;
   logic [P_MEM_DW-1:0] arr_dat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= (P_INIT_EN != 0) ? ST_INIT : ST_RUN;
         cnt <= '0;
      end else begin
         st <= st_nxt;
         if (st == ST_INIT) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      st_nxt  = st;
      m_ready = 1'b0;
      case (st)
         ST_INIT: if (cnt == '1) st_nxt = ST_RUN;
         ST_RUN:  m_ready = 1'b1;
         default: st_nxt = ST_RUN;
      endcase
   end

   assign wr_acc  = m_cs & ~m_rw & m_ready;
   assign rd_acc  = m_cs &  m_rw & m_ready;
   assign arr_dat = mem[m_addr];

   // The array has no reset. Updates are held off while rst_n is low so a
   // request presented during reset (m_ready can be high with no clear
   // sequence) cannot corrupt contents that are meant to survive reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (st == ST_INIT) begin
            mem[cnt] <= '0;
         end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++)
               if (m_be[i]) mem[m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
         end
      end
   end

   // The array word is sampled into stage 0 at the accepting edge, so a
   // later write to the same address cannot disturb a read already in flight.
   mem_rd_pipe #(
      .P_DW  (P_MEM_DW),
      .P_LAT (P_RD_LAT)
   ) u_rd_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld_vld (rd_acc),
      .ld_dat (arr_dat),
      .rd_vld (m_rvalid),
      .rd_dat (m_rdata)
   );

endmodule

// File: tb/tb_mem_mdl_pipe.sv
// Bench for mem_mdl_pipe: one clearing instance (latency 2) plus four
// non-clearing instances (latency 1..4) driven by the same request stream.
module tb_mem_mdl_pipe;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int N     = 2048;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs;
   logic        rw;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic        rdy_m, rv_m;
   logic [31:0] rd_m;
   logic        rdy_s [4];
   logic        rv_s  [4];
   logic [31:0] rd_s  [4];

   always #5 clk = ~clk;

   mem_mdl_pipe #(.P_MEM_DW(32), .P_MEM_AW(AW), .P_RD_LAT(2), .P_INIT_EN(1)) u_main (
      .clk(clk), .rst_n(rst_n), .m_cs(cs), .m_rw(rw), .m_addr(addr), .m_wdata(wdata),
      .m_be(be), .m_ready(rdy_m), .m_rdata(rd_m), .m_rvalid(rv_m));

   for (genvar g = 0; g < 4; g++) begin : g_sw
      mem_mdl_pipe #(.P_MEM_DW(32), .P_MEM_AW(AW), .P_RD_LAT(g + 1), .P_INIT_EN(0)) u_sw (
         .clk(clk), .rst_n(rst_n), .m_cs(cs), .m_rw(rw), .m_addr(addr), .m_wdata(wdata),
         .m_be(be), .m_ready(rdy_s[g]), .m_rdata(rd_s[g]), .m_rvalid(rv_s[g]));
   end

   // Reference model: word arrays, plus per-edge history of accepted reads.
   // The expected return for latency L after edge c is the read taken at edge c-L+1.
   int          nvec = 0;
   int          nerr = 0;
   int          cyc  = 0;
   int          rel  = 0;      // rising edges with reset released since last reset
   logic [31:0] mm [DEPTH];    // clearing instance
   logic [31:0] ms [DEPTH];    // non-clearing instances
   bit          hv_m [N];
   bit          hv_s [N];
   logic [31:0] hd_m [N];
   logic [31:0] hd_s [N];
   // Hand-written expectations attached to particular reads.
   bit          tw_m [N];
   bit          tw_s [N];
   logic [31:0] td_m [N];
   logic [31:0] td_s [N];
   bit          pend_m, pend_s;
   logic [31:0] pend_dm, pend_ds;

   typedef struct {
      bit          rw;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t tab [11];

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] b);
      logic [31:0] mask;
      mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      return (o & ~mask) | (d & mask);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic step();
      bit acc_m;
      int idx;
      bit ev;
      @(posedge clk);
      cyc++;
      if (cyc >= N) begin
         $display("FAIL cycle_budget cyc=%0d got=over expected=under %0d", cyc, N);
         $fatal(1, "cycle budget exhausted");
      end
      if (!rst_n) begin
         rel = 0;
         for (int i = 0; i < N; i++) begin
            hv_m[i] = 0; hv_s[i] = 0; tw_m[i] = 0; tw_s[i] = 0;
         end
      end else begin
         acc_m = cs && (rel >= DEPTH);
         if (cs && rw) begin hv_s[cyc] = 1; hd_s[cyc] = ms[addr]; end
         else if (cs)  ms[addr] = merge(ms[addr], wdata, be);
         if (acc_m && rw) begin hv_m[cyc] = 1; hd_m[cyc] = mm[addr]; end
         else if (acc_m)  mm[addr] = merge(mm[addr], wdata, be);
         tw_m[cyc] = pend_m; td_m[cyc] = pend_dm;
         tw_s[cyc] = pend_s; td_s[cyc] = pend_ds;
         rel++;
         if (rel == DEPTH) for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end
      pend_m = 0;
      pend_s = 0;
      @(negedge clk);
      chk("ready_main", {31'b0, rdy_m}, {31'b0, rel >= DEPTH});
      idx = cyc - 1;
      ev  = (idx >= 1) ? hv_m[idx] : 1'b0;
      chk("rvalid_main", {31'b0, rv_m}, {31'b0, ev});
      chk("rdata_main", rd_m, ev ? hd_m[idx] : 32'h0);
      if (idx >= 1 && tw_m[idx]) chk("directed_main", rd_m, td_m[idx]);
      for (int l = 1; l <= 4; l++) begin
         idx = cyc - l + 1;
         ev  = (idx >= 1) ? hv_s[idx] : 1'b0;
         chk($sformatf("ready_lat%0d", l), {31'b0, rdy_s[l-1]}, 32'h1);
         chk($sformatf("rvalid_lat%0d", l), {31'b0, rv_s[l-1]}, {31'b0, ev});
         chk($sformatf("rdata_lat%0d", l), rd_s[l-1], ev ? hd_s[idx] : 32'h0);
         if (idx >= 1 && tw_s[idx]) chk($sformatf("directed_lat%0d", l), rd_s[l-1], td_s[idx]);
      end
   endtask

   task automatic op(input bit c, input bit r, input int a, input logic [31:0] d,
                     input logic [3:0] b);
      cs = c; rw = r; addr = a[3:0]; wdata = d; be = b;
      step();
   endtask

   task automatic idle(input int n);
      repeat (n) op(0, 0, 0, 32'h0, 4'h0);
   endtask

   task automatic do_rst(input int n);
      rst_n = 1'b0;
      cs    = 1'b0;
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   initial begin
      tab[0]  = '{0, 4'd5, 32'h11223344, 4'hF, 32'h0};
      tab[1]  = '{0, 4'd5, 32'hAABBCCDD, 4'h5, 32'h0};
      tab[2]  = '{1, 4'd5, 32'h0,        4'h0, 32'h11BB33DD};
      tab[3]  = '{0, 4'd3, 32'hCAFE0003, 4'hF, 32'h0};
      tab[4]  = '{1, 4'd3, 32'h0,        4'h0, 32'hCAFE0003};
      tab[5]  = '{0, 4'd0, 32'h00000001, 4'hF, 32'h0};
      tab[6]  = '{1, 4'd0, 32'h0,        4'hA, 32'h00000001};
      tab[7]  = '{0, 4'd0, 32'h00000002, 4'hF, 32'h0};
      tab[8]  = '{1, 4'd0, 32'h0,        4'h0, 32'h00000002};
      tab[9]  = '{0, 4'd5, 32'hFFFFFFFF, 4'h0, 32'h0};
      tab[10] = '{1, 4'd5, 32'h0,        4'h0, 32'h11BB33DD};

      pend_m = 0; pend_s = 0; pend_dm = '0; pend_ds = '0;
      rst_n = 1'b0; cs = 0; rw = 0; addr = '0; wdata = '0; be = '0;

      // Power-up reset, then requests during the clear: only the
      // non-clearing instances take them.
      do_rst(3);
      for (int a = 0; a < DEPTH; a++) op(1, 0, a, $urandom, 4'hF);
      for (int a = 0; a < DEPTH; a++) begin
         pend_m = 1; pend_dm = 32'h0;
         op(1, 1, a, 32'h0, 4'h0);
      end
      idle(4);

      // Directed vectors.
      for (int i = 0; i < 11; i++) begin
         if (tab[i].rw) begin
            pend_m = 1; pend_dm = tab[i].exp;
            pend_s = 1; pend_ds = tab[i].exp;
         end
         op(1, tab[i].rw, int'(tab[i].addr), tab[i].wdata, tab[i].be);
         if (i == 4) idle(5);   // isolated read to see each latency alone
      end
      idle(5);

      // Random mixed traffic.
      for (int i = 0; i < 400; i++)
         op(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            $urandom, 4'($urandom_range(0, 15)));

      // Chip select low with other inputs toggling.
      for (int i = 0; i < 20; i++)
         op(0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom, 4'hF);
      for (int a = 0; a < DEPTH; a++) op(1, 1, a, 32'h0, 4'h0);
      idle(5);

      // Reset with two reads in flight.
      op(1, 1, 3, 32'h0, 4'h0);
      op(1, 1, 0, 32'h0, 4'h0);
      rst_n = 1'b0;
      cs    = 1'b0;
      #1;
      chk("rst_rvalid_main", {31'b0, rv_m}, 32'h0);
      for (int l = 0; l < 4; l++) chk($sformatf("rst_rvalid_lat%0d", l + 1), {31'b0, rv_s[l]}, 32'h0);
      do_rst(2);
      idle(20);

      // Fill with a pattern, reset, reset again mid-clear, and confirm the clear.
      for (int a = 0; a < DEPTH; a++) op(1, 0, a, 32'hDEADBEEF, 4'hF);
      idle(2);
      do_rst(2);
      idle(7);
      do_rst(2);
      idle(20);
      for (int a = 0; a < DEPTH; a++) begin
         pend_m = 1; pend_dm = 32'h0;
         pend_s = 1; pend_ds = 32'hDEADBEEF;
         op(1, 1, a, 32'h0, 4'h0);
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_mdl_pipe.md
Name: mem_mdl_pipe

Overview:
- Parametrised single-port synchronous memory model.
- Next generation of the team's simple memory model, adding:
  - per-byte write enables
  - a pipelined, configurable read latency with a read-valid strobe
  - an optional post-reset clear sequence gated by a ready flag
- Sits behind bus/DMA masters in block-level benches and as a behavioural RAM in subsystem sims.

Parameters:
- P_MEM_DW, 32, data width in bits; must be a multiple of 8.
- P_MEM_AW, 10, address width; depth = 2**P_MEM_AW words.
- P_RD_LAT, 2, read latency in cycles from accepted read to m_rvalid; legal 1..4.
- P_INIT_EN, 1, 1 = clear every word to zero after reset before accepting traffic; 0 = ready immediately.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m_cs  in  1  chip select; a request exists when high.
- m_rw  in  1  1 = read, 0 = write.
- m_addr  in  P_MEM_AW  word address.
- m_wdata  in  P_MEM_DW  write data.
- m_be  in  P_MEM_DW/8  byte enables; bit i covers m_wdata[8i+7:8i].
- m_ready  out  1  high when requests are accepted.
- m_rdata  out  P_MEM_DW  read data; valid only while m_rvalid is high, zero otherwise.
- m_rvalid  out  1  one-cycle strobe per accepted read.

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_rdata = 0, m_rvalid = 0, all read-pipe valid stages = 0, init counter = 0.
  - State = ST_INIT if P_INIT_EN = 1, else ST_RUN.
  - m_ready = 0 if P_INIT_EN = 1, else 1.
  - Array contents are not reset.
- State machine:
  - ST_INIT:
    - Each cycle writes 0 to mem[cnt], then cnt increments.
    - When cnt = 2**P_MEM_AW-1 is written, go to ST_RUN.
    - m_ready stays 0 throughout; any m_cs is ignored, with no write and no rvalid.
  - ST_RUN:
    - m_ready = 1.
    - Requests are accepted on the rising edge while m_cs & m_ready.
    - No return to ST_INIT except via reset.
- Init timing: m_ready rises exactly 2**P_MEM_AW cycles after the first rising edge with rst_n high.
- Write (m_cs & ~m_rw & m_ready):
  - For each i with m_be[i] = 1, mem[m_addr] byte i <= m_wdata byte i.
  - Bytes with m_be[i] = 0 are unchanged.
  - m_be = 0 is a legal no-op.
- Read (m_cs & m_rw & m_ready):
  - mem[m_addr] is sampled at the accepting edge.
  - Data appears on m_rdata with m_rvalid = 1 exactly P_RD_LAT cycles later, for one cycle.
  - m_be is ignored for reads.
- Throughput: fully pipelined; one request per cycle, reads and writes in any mix, no bubbles.
- Ordering:
  - A read accepted the cycle after a write to the same address returns the new data.
  - A write issued while an earlier read is in flight does not alter that read's data.
- m_rdata is driven to 0 whenever m_rvalid = 0. This is registered at the pipe output, not combinational from the array.
- m_cs low: no array or pipe change beyond normal pipe advance.
- Out-of-range addresses are impossible (full decode).
- Reset mid-operation:
  - In-flight reads are discarded; no m_rvalid is produced after reset assertion.
  - Reset during ST_INIT restarts the clear from address 0.
- Illegal parameters (P_MEM_DW % 8 != 0, or P_RD_LAT outside 1..4): elaboration-time $error.

Decomposition:
- Package mem_mdl_pkg:
  - state enum typedef mem_st_e {ST_INIT, ST_RUN}
  - constant MEM_MAX_RD_LAT = 4
  - function for byte-lane count (P_MEM_DW/8)
- Sub-module mem_rd_pipe:
  - Shift register of {valid, data}, depth P_RD_LAT, with async active-low reset of the valid bits and the output data register.
  - Stage 0 is loaded from the array read; the output stage drives m_rvalid/m_rdata.

Test Plan:
- Init clear (P_INIT_EN=1, AW=4): preload the array with 0xDEADBEEF by backdoor, release reset -> m_ready = 0 for 16 cycles, then 1; reading addresses 0..15 returns 0x00000000.
- Byte enables: write 0x11223344 to addr 5 with m_be=4'hF, then 0xAABBCCDD with m_be=4'b0101 -> read of addr 5 returns 0x11BB33DD.
- Latency (P_RD_LAT=1..4 sweep): single read of addr 3 holding 0xCAFE0003 -> m_rvalid high exactly P_RD_LAT cycles after the accepting edge, for one cycle, with m_rdata = 0xCAFE0003; m_rdata = 0 otherwise.
- Back-to-back mixed traffic: write A0=1; read A0; write A0=2; read A0 on consecutive cycles -> m_rvalid on two consecutive-pipe slots returning 1 then 2; no bubbles.
- Reset mid-init and mid-read:
  - Assert rst_n at init count 7 -> m_ready stays 0 for a full 2**AW cycles after release.
  - Assert rst_n with 2 reads in flight -> no m_rvalid afterwards.
- Ignored requests: m_cs pulses during ST_INIT, and m_cs=0 with toggling m_rw/m_addr in ST_RUN -> no array change, no m_rvalid; P_INIT_EN=0 -> m_ready = 1 on the first cycle after reset.
